s_axi_lite_registers_slave: RTL and testbench
=============================================

Name: s_axi_lite_registers_slave

Overview:
- AXI4-Lite responder (slave) for the hardware accelerator's configuration registers; the opposite end of the control-side AXI-Lite master.
- Holds operation_mode, burst size, transfer size, write address and read address, and drives them to the accelerator core.
- Exposes a read-only status word.
- Rejects configuration writes while the core is busy.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8, byte address width.

Ports:
- axi_aclk  in  1  sole clock; all logic on rising edge.
- axi_areset  in  1  reset, asynchronous, active-high.
- s_axi_awaddr in ADDR_WIDTH; s_axi_awprot in 3 (ignored); s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr in ADDR_WIDTH; s_axi_arprot in 3 (ignored); s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
- core_busy  in  1  accelerator operation in progress.
- operation_mode, burst_size, transfer_size, write_address, read_address  out  32 each  register contents.

Behaviour:
- Register map (byte offsets): 0 OPERATION_MODE, 4 BURST_SIZE, 8 TRANSFER_SIZE, 12 WRITE_ADDRESS, 16 READ_ADDRESS (all RW), 20 STATUS (RO: bit0 = core_busy, other bits 0).
- Decode uses addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Any other offset is unmapped.
- Reset: while axi_areset is high, every register output, s_axi_*ready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata and internal hold flags are 0.
- awready, wready and arready rise at the first clock edge after reset deasserts.
- Write path: AW and W are accepted independently, in either order or in the same cycle.
  - awready = not aw_held; the AW handshake latches awaddr and sets aw_held. W side is the same: wready = not w_held, handshake latches wdata/wstrb and sets w_held.
  - Commit happens at the edge where aw_held and w_held are both set and bvalid is 0. At that edge:
    - the register updates byte-wise per wstrb (a byte with strobe 0 keeps its old value);
    - bvalid <= 1 and bresp is set;
    - both hold flags clear.
  - bresp: OKAY (00) for a mapped RW offset with core_busy = 0. SLVERR (10), with no register change, for an unmapped offset, a write to STATUS, or core_busy = 1 sampled at the commit edge.
  - bvalid holds until the bready handshake, then clears.
  - While bvalid is pending, a new AW/W may be latched but is not committed until bvalid clears.
  - Latency: bvalid is high 2 cycles after the later of the AW/W handshakes.
- Read path, 2-state FSM R_IDLE/R_DATA:
  - R_IDLE: arready = 1. On the AR handshake: rdata <= decoded value, rvalid <= 1, arready <= 0, go to R_DATA.
  - Unmapped offset: rdata = 0, rresp = SLVERR; otherwise rresp = OKAY.
  - R_DATA: hold rdata/rresp/rvalid stable until rready. On the handshake: rvalid <= 0, arready <= 1, return to R_IDLE.
  - rvalid is high the cycle after the AR handshake.
- Simultaneous read and write to the same offset: the read returns the pre-commit value when the commit lands on the same edge as the AR handshake.
- Reset mid-transaction: hold flags, pending bvalid/rvalid and all registers clear immediately; the transaction is lost.

Decomposition:
- Shared package contains:
  - offset constants ADDR_OPERATION_MODE=0, ADDR_BURST_SIZE=4, ADDR_TRANSFER_SIZE=8, ADDR_WRITE_ADDRESS=12, ADDR_READ_ADDRESS=16, ADDR_STATUS=20;
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - operation mode values SEPARATE=0, MIX=1, FULLY_MIX=2;
  - a byte-strobe merge function.
- No sub-module is needed; the write and read channels are two always blocks in one module.

Test Plan:
- Reset then idle: all outputs 0 during reset; awready/wready/arready = 1 one cycle after release; read of offset 4 returns 0 with OKAY.
- AW at cycle 0 then W at cycle 3 writing 32 to offset 4, wstrb=4'hF -> burst_size = 32 at the commit; bvalid 2 cycles after W; bresp = 00; read of offset 4 returns 32.
- AW+W in the same cycle writing 0x12345678 to offset 12 with wstrb=4'b0101 over old value 0 -> write_address = 0x00340078; bresp OKAY.
- core_busy = 1 and write 2 to offset 0 -> bresp = 10, operation_mode unchanged; read offset 20 -> rdata = 1.
- Unmapped: write offset 0x40 -> bresp SLVERR; read offset 0x40 -> rdata 0, rresp SLVERR.
- Backpressure: hold bready/rready low 5 cycles -> bvalid/rvalid and rdata stay stable; arready stays low; a second AW/W is latched but not committed until the bready handshake; assert axi_areset mid-stall -> bvalid/rvalid drop immediately and all registers read 0.

Source files
------------

// File: rtl/s_axi_lite_registers_slave_pkg.sv
// Shared constants, types and helpers for the accelerator's
// AXI4-Lite configuration register slave.
package s_axi_lite_registers_slave_pkg;

    localparam int unsigned ADDR_OPERATION_MODE = 0;
    localparam int unsigned ADDR_BURST_SIZE     = 4;
    localparam int unsigned ADDR_TRANSFER_SIZE  = 8;
    localparam int unsigned ADDR_WRITE_ADDRESS  = 12;
    localparam int unsigned ADDR_READ_ADDRESS   = 16;
    localparam int unsigned ADDR_STATUS         = 20;

    localparam int unsigned NUM_RW_REGS = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [31:0] {
        SEPARATE  = 32'd0,
        MIX       = 32'd1,
        FULLY_MIX = 32'd2
    } op_mode_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/s_axi_lite_registers_slave_if.sv
// AXI4-Lite bus bundle between the control master and the
// configuration register slave.
interface s_axi_lite_registers_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [2:0]              s_axi_awprot;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [2:0]              s_axi_arprot;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface

// File: rtl/s_axi_lite_registers_slave.sv
// AXI4-Lite configuration register slave for the accelerator core:
// five RW config words plus a read-only busy status word.
module s_axi_lite_registers_slave
    import s_axi_lite_registers_slave_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    s_axi_lite_registers_slave_if.slave s_axi,
    input  logic        core_busy,
    output logic [31:0] operation_mode,
    output logic [31:0] burst_size,
    output logic [31:0] transfer_size,
    output logic [31:0] write_address,
    output logic [31:0] read_address
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    // 0..4 select an RW register, 5 is STATUS, 7 is unmapped.
    function automatic logic [2:0] decode(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = {a[AW-1:2], 2'b00};
        unique case (1'b1)
            (off == AW'(ADDR_OPERATION_MODE)): decode = 3'd0;
            (off == AW'(ADDR_BURST_SIZE)):     decode = 3'd1;
            (off == AW'(ADDR_TRANSFER_SIZE)):  decode = 3'd2;
            (off == AW'(ADDR_WRITE_ADDRESS)):  decode = 3'd3;
            (off == AW'(ADDR_READ_ADDRESS)):   decode = 3'd4;
            (off == AW'(ADDR_STATUS)):         decode = 3'd5;
            default:                           decode = 3'd7;
        endcase
    endfunction

    logic [31:0]   regs_q [NUM_RW_REGS];
    logic [31:0]   regs_d [NUM_RW_REGS];
    logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic          awready_q, awready_d, wready_q, wready_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          commit, wr_ok;
    logic [2:0]    wr_idx;

    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_idx    = decode(awaddr_q);
        commit    = aw_held_q & w_held_q & ~bvalid_q;
        wr_ok     = (wr_idx < 3'd5) & ~core_busy;
        if (s_axi.s_axi_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.s_axi_awaddr;
        end
        if (s_axi.s_axi_wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.s_axi_wdata;
            wstrb_d  = s_axi.s_axi_wstrb;
        end
        if (bvalid_q && s_axi.s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
                regs_d[wr_idx] = strb_merge(regs_q[wr_idx], wdata_q, wstrb_q);
            end
        end
        awready_d = ~aw_held_d;
        wready_d  = ~w_held_d;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    rd_state_e                     r_state_q, r_state_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]                    rd_idx;
    logic [31:0]                   rd_val;
    logic                          rd_err;

    // Reads see pre-commit register contents on a coinciding edge.
    always_comb begin
        rd_idx = decode(s_axi.s_axi_araddr);
        rd_val = '0;
        rd_err = 1'b0;
        if (rd_idx < 3'd5) begin
            rd_val = regs_q[rd_idx];
        end else if (rd_idx == 3'd5) begin
            rd_val = {31'b0, core_busy};
        end else begin
            rd_err = 1'b1;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi.s_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    logic unused_prot;
    assign unused_prot = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot};

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign s_axi.s_axi_rdata   = rdata_q;

    assign operation_mode = regs_q[0];
    assign burst_size     = regs_q[1];
    assign transfer_size  = regs_q[2];
    assign write_address  = regs_q[3];
    assign read_address   = regs_q[4];

endmodule

// File: tb/tb_s_axi_lite_registers_slave.sv
// Directed bench for the AXI4-Lite config register slave with a
// register-map model checked every cycle.
module tb_s_axi_lite_registers_slave;
    import s_axi_lite_registers_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_busy;
    logic [31:0] op_mode, burst, xfer, waddr, raddr;
    logic [31:0] dut_regs [5];

    always #5 clk = ~clk;

    s_axi_lite_registers_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    s_axi_lite_registers_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(8)
    ) dut (
        .axi_aclk       (clk),
        .axi_areset     (rst),
        .s_axi          (bus),
        .core_busy      (core_busy),
        .operation_mode (op_mode),
        .burst_size     (burst),
        .transfer_size  (xfer),
        .write_address  (waddr),
        .read_address   (raddr)
    );

    assign dut_regs[0] = op_mode;
    assign dut_regs[1] = burst;
    assign dut_regs[2] = xfer;
    assign dut_regs[3] = waddr;
    assign dut_regs[4] = raddr;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic [31:0] model [5];
    wr_t         pend [$];

    function automatic logic [1:0] model_wresp(input logic [7:0] a);
        return ((a / 4) < 5 && !core_busy) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [33:0] model_read(input logic [7:0] a);
        int idx;
        idx = a / 4;
        if (idx < 5) return {2'b00, model[idx]};
        if (idx == 5) return {2'b00, 31'd0, core_busy};
        return {2'b10, 32'd0};
    endfunction

    logic        bv_prev = 0, rv_prev = 0, br_prev = 0, rr_prev = 0;
    logic [1:0]  bresp_prev = 0, rresp_prev = 0;
    logic [31:0] rdata_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) model[i] = 32'd0;
            pend.delete();
            chk("rst_awready", bus.s_axi_awready, 0);
            chk("rst_wready", bus.s_axi_wready, 0);
            chk("rst_arready", bus.s_axi_arready, 0);
            chk("rst_bvalid", bus.s_axi_bvalid, 0);
            chk("rst_rvalid", bus.s_axi_rvalid, 0);
            chk("rst_bresp", bus.s_axi_bresp, 0);
            chk("rst_rresp", bus.s_axi_rresp, 0);
            chk("rst_rdata", bus.s_axi_rdata, 0);
        end else begin
            if (bus.s_axi_bvalid && !bv_prev) begin
                chk("b_pending_nonempty", 32'(pend.size() > 0), 1);
                if (pend.size() > 0) begin
                    wr_t w;
                    logic [1:0] er;
                    w  = pend.pop_front();
                    er = model_wresp(w.addr);
                    chk("bresp_model", bus.s_axi_bresp, er);
                    if (er == 2'b00) begin
                        for (int b = 0; b < 4; b++)
                            if (w.strb[b])
                                model[w.addr / 4][8*b +: 8] = w.data[8*b +: 8];
                    end
                end
            end
            if (bv_prev && !br_prev) begin
                chk("b_hold", bus.s_axi_bvalid, 1);
                chk("b_stable", bus.s_axi_bresp, bresp_prev);
            end
            if (rv_prev && !rr_prev) begin
                chk("r_hold", bus.s_axi_rvalid, 1);
                chk("r_stable_data", bus.s_axi_rdata, rdata_prev);
                chk("r_stable_resp", bus.s_axi_rresp, rresp_prev);
            end
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("reg%0d", i), dut_regs[i], model[i]);
        bv_prev    = rst ? 1'b0 : bus.s_axi_bvalid;
        rv_prev    = rst ? 1'b0 : bus.s_axi_rvalid;
        br_prev    = bus.s_axi_bready;
        rr_prev    = bus.s_axi_rready;
        bresp_prev = bus.s_axi_bresp;
        rresp_prev = bus.s_axi_rresp;
        rdata_prev = bus.s_axi_rdata;
    end

    task automatic send_aw(input logic [7:0] a);
        int n = 0;
        @(posedge clk); #1;
        bus.s_axi_awaddr  = a;
        bus.s_axi_awvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_axi_awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_in_time", 32'(n < 20), 1);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(posedge clk); #1;
        bus.s_axi_wdata  = d;
        bus.s_axi_wstrb  = s;
        bus.s_axi_wvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_axi_wready && n < 20) begin @(negedge clk); n++; end
        chk("w_in_time", 32'(n < 20), 1);
        @(posedge clk); #1;
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic write_hs(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        pend.push_back('{a, d, s});
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic wait_bv();
        int n = 0;
        while (!bus.s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        chk("b_in_time", 32'(n < 20), 1);
    endtask

    task automatic wait_b(input int hold, output logic [1:0] resp);
        wait_bv();
        resp = bus.s_axi_bresp;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 bus.s_axi_bready = 1'b1;
        @(posedge clk); #1 bus.s_axi_bready = 1'b0;
    endtask

    task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, output logic [1:0] resp);
        write_hs(a, d, s);
        wait_b(hold, resp);
    endtask

    task automatic rd(input logic [7:0] a, input int hold,
                      output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        logic [33:0] e;
        @(posedge clk); #1;
        bus.s_axi_araddr  = a;
        bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_axi_arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_in_time", 32'(n < 20), 1);
        #1 e = model_read(a);
        @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("r_valid", bus.s_axi_rvalid, 1);
        chk("r_data", bus.s_axi_rdata, e[31:0]);
        chk("r_resp", bus.s_axi_rresp, e[33:32]);
        d    = bus.s_axi_rdata;
        resp = bus.s_axi_rresp;
        repeat (hold) begin
            @(negedge clk);
            chk("r_arready_low", bus.s_axi_arready, 0);
        end
        @(posedge clk); #1 bus.s_axi_rready = 1'b1;
        @(posedge clk); #1 bus.s_axi_rready = 1'b0;
    endtask

    logic [31:0] d;
    logic [1:0]  r, rr;

    initial begin
        rst = 1'b1;
        core_busy = 1'b0;
        bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 0;
        bus.s_axi_bready = 0;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 0;
        bus.s_axi_rready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("awready_up", bus.s_axi_awready, 1);
        chk("wready_up", bus.s_axi_wready, 1);
        chk("arready_up", bus.s_axi_arready, 1);
        rd(8'd4, 0, d, r);
        chk("idle_rd4", d, 32'd0);
        chk("idle_rd4_resp", r, 2'b00);

        // AW first, W three cycles later; bvalid two cycles after W.
        pend.push_back('{8'd4, 32'd32, 4'hF});
        send_aw(8'd4);
        repeat (2) @(posedge clk);
        send_w(32'd32, 4'hF);
        @(negedge clk);
        chk("lat_b_early", bus.s_axi_bvalid, 0);
        @(negedge clk);
        chk("lat_b_on_time", bus.s_axi_bvalid, 1);
        chk("lat_burst", burst, 32'd32);
        chk("lat_bresp", bus.s_axi_bresp, 2'b00);
        wait_b(0, r);
        rd(8'd4, 0, d, r);
        chk("rd_burst32", d, 32'd32);

        write(8'd12, 32'h1234_5678, 4'b0101, 0, r);
        chk("strb_waddr", waddr, 32'h0034_0078);
        chk("strb_bresp", r, 2'b00);

        core_busy = 1'b1;
        write(8'd0, 32'd2, 4'hF, 0, r);
        chk("busy_bresp", r, 2'b10);
        chk("busy_opmode", op_mode, 32'd0);
        rd(8'd20, 0, d, r);
        chk("status_busy", d, 32'd1);
        core_busy = 1'b0;
        rd(8'd20, 0, d, r);
        chk("status_idle", d, 32'd0);
        write(8'd0, 32'(FULLY_MIX), 4'hF, 0, r);
        chk("opmode_fmix", op_mode, 32'd2);

        write(8'h40, 32'hDEAD_BEEF, 4'hF, 0, r);
        chk("unmapped_bresp", r, 2'b10);
        rd(8'h40, 0, d, r);
        chk("unmapped_rdata", d, 32'd0);
        chk("unmapped_rresp", r, 2'b10);
        write(8'd20, 32'hFFFF_FFFF, 4'hF, 0, r);
        chk("status_wr_bresp", r, 2'b10);
        write(8'h07, 32'h0000_0055, 4'b0001, 0, r);
        chk("lowbits_burst", burst, 32'h0000_0055);

        // Read lands on the same edge as the commit: old value.
        fork
            write(8'd16, 32'hCAFE_F00D, 4'hF, 0, r);
            begin
                @(posedge clk);
                rd(8'd16, 0, d, rr);
            end
        join
        chk("simul_pre", d, 32'd0);
        rd(8'd16, 0, d, r);
        chk("simul_post", d, 32'hCAFE_F00D);

        // Second write latched behind a stalled response.
        write_hs(8'd8, 32'h1111_0000, 4'hF);
        wait_bv();
        write_hs(8'd8, 32'h0000_2222, 4'b0011);
        repeat (5) begin
            @(negedge clk);
            chk("bp_bvalid", bus.s_axi_bvalid, 1);
            chk("bp_xfer_hold", xfer, 32'h1111_0000);
            chk("bp_aw_latched", bus.s_axi_awready, 0);
        end
        @(posedge clk); #1 bus.s_axi_bready = 1'b1;
        @(posedge clk); #1 bus.s_axi_bready = 1'b0;
        @(negedge clk);
        chk("bp_b_drop", bus.s_axi_bvalid, 0);
        @(negedge clk);
        chk("bp_b_second", bus.s_axi_bvalid, 1);
        chk("bp_xfer_merged", xfer, 32'h1111_2222);
        wait_b(0, r);
        rd(8'd8, 5, d, r);
        chk("bp_rd", d, 32'h1111_2222);

        // Reset in the middle of stalled responses.
        write_hs(8'd0, 32'h0000_00AA, 4'hF);
        wait_bv();
        @(posedge clk); #1;
        bus.s_axi_araddr  = 8'd4;
        bus.s_axi_arvalid = 1'b1;
        @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("mid_rvalid", bus.s_axi_rvalid, 1);
        chk("mid_opmode", op_mode, 32'h0000_00AA);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", bus.s_axi_bvalid, 0);
        chk("mid_rst_rvalid", bus.s_axi_rvalid, 0);
        chk("mid_rst_opmode", op_mode, 32'd0);
        chk("mid_rst_xfer", xfer, 32'd0);
        chk("mid_rst_raddr", raddr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_arready", bus.s_axi_arready, 1);
        rd(8'd0, 0, d, r);
        chk("post_rst_rd0", d, 32'd0);
        rd(8'd8, 0, d, r);
        chk("post_rst_rd8", d, 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
